// File: rtl/uart_pkg.sv
// Shared definitions for the Mode 2 UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        TB8   = 3'd3,
        STOP  = 3'd4
    } uart_state_e;

    localparam int   FRAME_BITS  = 11;
    localparam int   DATA_BITS   = 8;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Even parity over a data byte, for callers that use the 9th bit as parity.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..P-1 and pulses bit_tick on the last count.
// P is CLK_PER_BIT when smod=1, otherwise 2*CLK_PER_BIT. restart holds the count at 0.
module uart_bit_timer #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic smod,
    output logic bit_tick
);

    localparam int CW = $clog2(2 * CLK_PER_BIT);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] last_s;

    // Terminal count for the selected baud rate.
    always_comb begin
        if (smod) begin
            last_s = CW'(CLK_PER_BIT - 1);
        end else begin
            last_s = CW'(2 * CLK_PER_BIT - 1);
        end
    end

    // One-cycle tick on the final cycle of each bit period.
    always_comb begin
        if (restart) begin
            bit_tick = 1'b0;
        end else begin
            bit_tick = (cnt_r == last_s);
        end
    end

    // Counter: cleared by reset or restart, wraps after the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (restart) begin
            cnt_r <= '0;
        end else if (cnt_r == last_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/uart_mode2_tx.sv
// 8051-style UART Mode 2 transmitter: start, D0..D7 LSB first, TB8, stop.
// All outputs come straight from flops; ti is a sticky flag where set beats clear.
module uart_mode2_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       tb8,
    input  logic       smod,
    input  logic       ti_clr,
    output logic       txd,
    output logic       busy,
    output logic       ti
);

    uart_state_e state_r, state_n;
    logic [8:0]  shreg_r, shreg_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic        smod_r, smod_n;
    logic        txd_r, txd_n;
    logic        busy_r, busy_n;
    logic        ti_r, ti_n;
    logic        ti_set_s;
    logic        restart_s;
    logic        bit_tick_s;

    uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart_s),
        .smod     (smod_r),
        .bit_tick (bit_tick_s)
    );

    // Next-state logic; the timer is held at zero while idle so the start bit gets a full period.
    always_comb begin
        state_n   = state_r;
        shreg_n   = shreg_r;
        bit_cnt_n = bit_cnt_r;
        smod_n    = smod_r;
        txd_n     = txd_r;
        busy_n    = busy_r;
        ti_set_s  = 1'b0;
        restart_s = 1'b0;
        case (state_r)
            IDLE: begin
                restart_s = 1'b1;
                if (start) begin
                    state_n   = START;
                    shreg_n   = {tb8, data_in};
                    smod_n    = smod;
                    txd_n     = START_LEVEL;
                    busy_n    = 1'b1;
                    bit_cnt_n = 3'd0;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (bit_tick_s) begin
                    state_n   = DATA;
                    txd_n     = shreg_r[0];
                    shreg_n   = {1'b0, shreg_r[8:1]};
                    bit_cnt_n = 3'd0;
                end else begin
                    state_n = START;
                end
            end
            DATA: begin
                // After each shift, shreg_r[0] already holds the next bit (TB8 after D7).
                if (bit_tick_s) begin
                    txd_n   = shreg_r[0];
                    shreg_n = {1'b0, shreg_r[8:1]};
                    if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
                        state_n = TB8;
                    end else begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                    end
                end else begin
                    state_n = DATA;
                end
            end
            TB8: begin
                if (bit_tick_s) begin
                    state_n  = STOP;
                    txd_n    = STOP_LEVEL;
                    ti_set_s = 1'b1;
                end else begin
                    state_n = TB8;
                end
            end
            STOP: begin
                if (bit_tick_s) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    state_n = STOP;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = STOP_LEVEL;
                busy_n  = 1'b0;
            end
        endcase
    end

    // Interrupt flag: a set in the same cycle as a clear must not be lost.
    always_comb begin
        if (ti_set_s) begin
            ti_n = 1'b1;
        end else if (ti_clr) begin
            ti_n = 1'b0;
        end else begin
            ti_n = ti_r;
        end
    end

    // State and output registers; reset returns the line to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            shreg_r   <= 9'd0;
            bit_cnt_r <= 3'd0;
            smod_r    <= 1'b0;
            txd_r     <= STOP_LEVEL;
            busy_r    <= 1'b0;
            ti_r      <= 1'b0;
        end else begin
            state_r   <= state_n;
            shreg_r   <= shreg_n;
            bit_cnt_r <= bit_cnt_n;
            smod_r    <= smod_n;
            txd_r     <= txd_n;
            busy_r    <= busy_n;
            ti_r      <= ti_n;
        end
    end

    assign txd  = txd_r;
    assign busy = busy_r;
    assign ti   = ti_r;

endmodule

// File: tb/tb_uart_mode2_tx.sv
// Directed bench for uart_mode2_tx with CLK_PER_BIT=4.
module tb_uart_mode2_tx;
    import uart_pkg::*;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       tb8;
    logic       smod;
    logic       ti_clr;
    logic       txd;
    logic       busy;
    logic       ti;

    int checks;
    int failures;
    logic ti_model;

    uart_mode2_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .tb8     (tb8),
        .smod    (smod),
        .ti_clr  (ti_clr),
        .txd     (txd),
        .busy    (busy),
        .ti      (ti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sends one frame starting at the current negedge and checks txd/busy/ti every cycle
    // until busy has fallen. Returns at the negedge where busy is first low.
    // ign_at: cycle index at which a start pulse (8'h3C) is fired while busy (-1 = none).
    // clr_at/clr_len: window of cycles with ti_clr held high.
    task automatic send_frame(input string name, input logic [7:0] d, input logic b8,
                              input logic sm, input int ign_at, input int clr_at,
                              input int clr_len, input logic clr_on_start);
        int p;
        logic [10:0] frame;
        logic clr_prev;
        logic exp_txd;
        logic exp_busy;
        p = sm ? CPB : 2 * CPB;
        frame = {1'b1, b8, d, 1'b0};
        start = 1'b1;
        data_in = d;
        tb8 = b8;
        smod = sm;
        ti_clr = clr_on_start;
        @(negedge clk);
        start = 1'b0;
        ti_clr = 1'b0;
        data_in = ~d;
        tb8 = ~b8;
        smod = ~sm;
        clr_prev = 1'b0;
        for (int j = 0; j <= 11 * p; j++) begin
            if (j == 0) begin
                if (clr_on_start) ti_model = 1'b0;
            end else if (j == 10 * p) begin
                ti_model = 1'b1;
            end else if (clr_prev) begin
                ti_model = 1'b0;
            end
            exp_txd  = (j < 11 * p) ? frame[j / p] : 1'b1;
            exp_busy = (j < 11 * p);
            checks++;
            if (txd !== exp_txd) begin
                failures++;
                $display("FAIL %s txd cycle=%0d got=%b exp=%b", name, j, txd, exp_txd);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL %s busy cycle=%0d got=%b exp=%b", name, j, busy, exp_busy);
            end
            checks++;
            if (ti !== ti_model) begin
                failures++;
                $display("FAIL %s ti cycle=%0d got=%b exp=%b", name, j, ti, ti_model);
            end
            if (j < 11 * p) begin
                start = (j == ign_at);
                if (j == ign_at) data_in = 8'h3C;
                ti_clr = (j >= clr_at) && (j < clr_at + clr_len);
                clr_prev = ti_clr;
                @(negedge clk);
            end
        end
        start = 1'b0;
        ti_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        data_in = 8'h00;
        tb8 = 1'b0;
        smod = 1'b1;
        ti_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({txd, busy, ti} !== 3'b100) begin
            failures++;
            $display("FAIL reset_hold got txd/busy/ti=%b exp=100", {txd, busy, ti});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({txd, busy, ti} !== 3'b100) begin
            failures++;
            $display("FAIL reset_idle got txd/busy/ti=%b exp=100", {txd, busy, ti});
        end
        ti_model = 1'b0;
    endtask

    task automatic test_frame_smod1();
        send_frame("frame_a5_smod1", 8'hA5, 1'b1, 1'b1, -1, -1, 0, 1'b1);
    endtask

    task automatic test_frame_smod0();
        @(negedge clk);
        send_frame("frame_a5_smod0", 8'hA5, 1'b1, 1'b0, -1, -1, 0, 1'b1);
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        send_frame("ignore_mid", 8'h5A, 1'b0, 1'b1, 10, -1, 0, 1'b1);
        @(negedge clk);
        send_frame("ignore_last", 8'h81, 1'b1, 1'b1, 11 * CPB - 1, -1, 0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({txd, busy} !== 2'b10) begin
                failures++;
                $display("FAIL ignore_no_restart got txd/busy=%b exp=10", {txd, busy});
            end
        end
    endtask

    task automatic test_ti_clr();
        @(negedge clk);
        send_frame("ti_clr_race", 8'hFF, 1'b0, 1'b1, -1, 10 * CPB - 1, 2, 1'b1);
        @(negedge clk);
        send_frame("ti_clr_noop", 8'h00, 1'b1, 1'b1, -1, 2, 3, 1'b1);
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        start = 1'b1;
        data_in = 8'hC3;
        tb8 = 1'b0;
        smod = 1'b1;
        ti_clr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        checks++;
        if ({busy, ti} !== 2'b11) begin
            failures++;
            $display("FAIL midframe_pre got busy/ti=%b exp=11", {busy, ti});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({txd, busy, ti} !== 3'b100) begin
            failures++;
            $display("FAIL midframe_rst got txd/busy/ti=%b exp=100", {txd, busy, ti});
        end
        @(negedge clk);
        rst = 1'b0;
        ti_model = 1'b0;
        @(negedge clk);
        send_frame("after_reset", 8'h96, 1'b1, 1'b1, -1, -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send_frame("b2b_0", 8'h01, even_parity(8'h01), 1'b1, -1, -1, 0, 1'b1);
        send_frame("b2b_1", 8'h7E, even_parity(8'h7E), 1'b0, -1, -1, 0, 1'b1);
        send_frame("b2b_2", 8'h80, even_parity(8'h80), 1'b1, -1, -1, 0, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ti_model = 1'b0;
        test_reset();
        test_frame_smod1();
        test_frame_smod0();
        test_busy_ignore();
        test_ti_clr();
        test_reset_midframe();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
